// File: rtl/instr_fetch_queue.sv
// RV32I fetch stage: PC, variable-latency imem requests, in-order instruction queue.
// Optional FETCH_ALIGN_CHECK_EN: flag misaligned redirect targets and stall fetch.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_misaligned
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [AW-1:0] q_rd, q_wr;
    logic [AW-1:0] t_rd, t_wr;
    logic [31:0]   q_data [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   tag    [DEPTH];
    logic [31:0]   hold_instr, hold_pc;
    logic [31:0]   redir_pc;
    logic          misaligned;
    logic [CW:0]   used;
    logic          req_fire, rsp_take, pop;

`ifdef FETCH_ALIGN_CHECK_EN
    logic mis_q;

    // Sticky misalignment flag, cleared by reset or an aligned redirect
    always_ff @(posedge clk) begin
        if (rst)
            mis_q <= 1'b0;
        else if (redirect_valid)
            mis_q <= |redirect_pc[1:0];
    end

    assign misaligned = mis_q;
    assign redir_pc   = redirect_pc;
`else
    assign misaligned = 1'b0;
    assign redir_pc   = redirect_pc & 32'hFFFF_FFFC;
`endif

    // Credit: buffered plus in-flight fetches never exceed DEPTH
    assign used = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !redirect_valid && !misaligned
                            && (used < LIMIT);
    assign imem_addr = pc;
    assign req_fire  = imem_req_valid && imem_req_ready;
    assign rsp_take  = imem_rsp_valid && (drop == '0);

    assign instr_valid      = (count != '0);
    assign instr            = instr_valid ? q_data[q_rd] : hold_instr;
    assign instr_pc         = instr_valid ? q_pc[q_rd]   : hold_pc;
    assign pop              = instr_valid && instr_ready;
    assign fetch_misaligned = misaligned;

    // PC, pointers and in-flight accounting; redirect overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            t_rd        <= '0;
            t_wr        <= '0;
        end else if (redirect_valid) begin
            // Every in-flight request not yet dropped becomes dropped;
            // an arriving response is discarded this cycle either way.
            pc          <= redir_pc;
            count       <= '0;
            outstanding <= '0;
            drop        <= drop + outstanding - CW'(imem_rsp_valid);
            q_rd        <= '0;
            q_wr        <= '0;
            t_rd        <= '0;
            t_wr        <= '0;
        end else begin
            if (req_fire) begin
                pc   <= pc + 32'd4;
                t_wr <= t_wr + AW'(1);
            end
            if (imem_rsp_valid && !rsp_take)
                drop <= drop - CW'(1);
            if (rsp_take) begin
                q_wr <= q_wr + AW'(1);
                t_rd <= t_rd + AW'(1);
            end
            if (pop)
                q_rd <= q_rd + AW'(1);
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
            count       <= count + CW'(rsp_take) - CW'(pop);
        end
    end

    // Queue and PC-tag storage; no reset needed behind the pointers
    always_ff @(posedge clk) begin
        if (req_fire)
            tag[t_wr] <= pc;
        if (!rst && !redirect_valid && rsp_take) begin
            q_data[q_wr] <= imem_rsp_data;
            q_pc[q_wr]   <= tag[t_rd];
        end
    end

    // Remember the last head shown so outputs hold while empty
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_instr <= '0;
            hold_pc    <= '0;
        end else if (instr_valid) begin
            hold_instr <= instr;
            hold_pc    <= instr_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-based reference model, in-order
// variable-latency memory model, directed scenarios plus random traffic.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        fetch_misaligned;

    always #5 clk = ~clk;

    instr_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_addr        (imem_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          rdy;
        bit          stale;
    } req_t;

    ent_t        expq[$];
    req_t        memq[$];
    logic [31:0] m_pc   = RESET_PC;
    bit          m_mis  = 1'b0;
    logic [31:0] last_i = '0;
    logic [31:0] last_p = '0;
    int          cyc    = 0;
    int          lat    = 1;
    int          total  = 0;
    int          bad    = 0;
    logic [31:0] alog[$];
    int          hs_n;
    bit          s_valid, s_rv, s_mis, s_rsp;
    logic [31:0] s_instr, s_pc, s_addr;

    function automatic logic [31:0] mdata(logic [31:0] a);
        return a * 32'h0001_0003 + 32'h1357_0000;
    endfunction

    function automatic void chk(string nm, logic [31:0] got,
                                logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endfunction

    function automatic int live();
        int n = 0;
        foreach (memq[i]) if (!memq[i].stale) n++;
        return n;
    endfunction

    function automatic bit exp_rv();
        return !rst && !redirect_valid && !m_mis &&
               (expq.size() + live() < DEPTH);
    endfunction

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        chk("req_valid", imem_req_valid, exp_rv());
        if (!rst) begin
            if (exp_rv()) chk("imem_addr", imem_addr, m_pc);
            chk("misaligned", fetch_misaligned, m_mis);
            chk("instr_valid", instr_valid, expq.size() != 0);
            if (expq.size() != 0) begin
                chk("instr", instr, expq[0].data);
                chk("instr_pc", instr_pc, expq[0].pc);
                last_i = expq[0].data;
                last_p = expq[0].pc;
            end else begin
                chk("instr_hold", instr, last_i);
                chk("instr_pc_hold", instr_pc, last_p);
            end
        end
    end

    task automatic mupdate();
        bit   rv  = exp_rv();
        bit   rsp = imem_rsp_valid;
        req_t e;
        if (rst) begin
            expq.delete();
            memq.delete();
            m_pc   = RESET_PC;
            m_mis  = 1'b0;
            last_i = '0;
            last_p = '0;
        end else begin
            if (rsp) e = memq.pop_front();
            if (redirect_valid) begin
                expq.delete();
                foreach (memq[i]) memq[i].stale = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                m_pc  = redirect_pc;
                m_mis = (redirect_pc[1:0] != 2'b00);
`else
                m_pc  = redirect_pc & 32'hFFFF_FFFC;
`endif
            end else begin
                if (expq.size() != 0 && instr_ready)
                    void'(expq.pop_front());
                if (rsp && !e.stale)
                    expq.push_back('{e.addr, mdata(e.addr)});
                if (rv && imem_req_ready) begin
                    memq.push_back('{m_pc, cyc + lat, 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    task automatic step();
        if (memq.size() != 0 && memq[0].rdy <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mdata(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        s_valid = instr_valid;
        s_instr = instr;
        s_pc    = instr_pc;
        s_rv    = imem_req_valid;
        s_addr  = imem_addr;
        s_mis   = fetch_misaligned;
        s_rsp   = imem_rsp_valid;
        if (imem_req_valid && imem_req_ready) begin
            alog.push_back(imem_addr);
            hs_n++;
        end
        @(posedge clk);
        mupdate();
        #1;
    endtask

    task automatic do_reset();
        int n = 0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        while (memq.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain_bound", memq.size(), 0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        alog.delete();
        hs_n = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int first, thr, k;
        bit found;
        logic [31:0] rp;

        rst            = 1'b1;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        hs_n           = 0;
        step();
        step();

        // Reset state, zero-wait memory, back-to-back fetch
        rst            = 1'b0;
        instr_ready    = 1'b1;
        imem_req_ready = 1'b1;
        alog.delete();
        first = -1;
        thr   = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 0) begin
                chk("rst_instr_valid", s_valid, 0);
                chk("rst_instr", s_instr, 0);
                chk("rst_instr_pc", s_pc, 0);
                chk("rst_misaligned", s_mis, 0);
                chk("rst_first_req", s_rv, 1);
                chk("rst_first_addr", s_addr, 0);
            end
            if (s_valid && first < 0) begin
                first = i;
                chk("first_pc", s_pc, 32'h0);
                chk("first_instr", s_instr, 32'h1357_0000);
            end
            if (i >= 10 && s_valid) thr++;
        end
        chk("first_valid_delay", first, 2);
        chk("throughput", thr, 10);
        for (int j = 0; j < 5; j++)
            chk("seq_addr", alog[j], 32'(4 * j));

        // Decode stalled: credit stops at DEPTH, head holds
        do_reset();
        lat            = 1;
        instr_ready    = 1'b0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("full_accepts", hs_n, 4);
        chk("full_req_valid", s_rv, 0);
        chk("full_valid", s_valid, 1);
        chk("full_head_pc", s_pc, 32'h0);
        chk("full_head_instr", s_instr, 32'h1357_0000);
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Redirect with two requests in flight, 3-cycle memory
        do_reset();
        lat            = 3;
        instr_ready    = 1'b1;
        imem_req_ready = 1'b1;
        step();
        step();
        chk("inflight_before_redirect", hs_n, 2);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = s_valid;
        end
        chk("redirect_found", found, 1);
        chk("redirect_pc", s_pc, 32'h100);
        chk("redirect_instr", s_instr, 32'h1457_0300);

        // Redirect coinciding with pop and response arrival
        lat = 1;
        for (int i = 0; i < 8; i++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        chk("coincide_pop", s_valid, 1);
        chk("coincide_rsp", s_rsp, 1);
        redirect_valid = 1'b0;
        step();
        chk("flush_empty", s_valid, 0);
        for (int i = 0; i < 10; i++) step();

        // PC wraps at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        alog.delete();
        for (int i = 0; i < 4; i++) step();
        chk("wrap_count", alog.size() >= 3, 1);
        if (alog.size() >= 3) begin
            chk("wrap_a0", alog[0], 32'hFFFF_FFF8);
            chk("wrap_a1", alog[1], 32'hFFFF_FFFC);
            chk("wrap_a2", alog[2], 32'h0000_0000);
        end

        // Unaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
        redirect_valid = 1'b0;
        step();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_set", s_mis, 1);
        chk("mis_no_req", s_rv, 0);
        for (int i = 0; i < 3; i++) step();
        chk("mis_sticky", s_mis, 1);
        chk("mis_still_no_req", s_rv, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        step();
        chk("mis_cleared", s_mis, 0);
        chk("mis_resume_req", s_rv, 1);
        chk("mis_resume_addr", s_addr, 32'h200);
`else
        chk("unaligned_flag", s_mis, 0);
        chk("unaligned_req", s_rv, 1);
        chk("unaligned_addr", s_addr, 32'h100);
`endif
        for (int i = 0; i < 6; i++) step();

        // Randomized traffic with one mid-run reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            instr_ready    = ($urandom % 4) != 0;
            imem_req_ready = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 20) == 0;
            k  = $urandom % 4;
            rp = (k == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            if ($urandom % 8 == 0) rp = rp | 32'($urandom_range(3, 0));
            redirect_pc = rp;
            lat = 1 + ($urandom % 3);
            step();
        end
        redirect_valid = 1'b0;
        rp = 32'h0;
        redirect_valid = 1'b1;
        redirect_pc    = rp;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
